// File: rtl/fsm_seq_gen.sv
// fsm_seq_gen: serial pattern generator. Sends a latched PAT_W-bit pattern
// MSB first, max(reps,1) times, with a one-cycle gap between repetitions and
// a one-cycle done pulse at the end. A stall input pauses the serial stream.
// Optional feature: define SEQ_GEN_PARITY_EN to append an even-parity bit
// after every transmission of the pattern.
// All outputs are registered; the registered state always describes the
// cycle that is currently visible on the outputs.
module fsm_seq_gen #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] reps,
    input  logic             stall,
    output logic             x,
    output logic             x_vld,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SHIFT = 3'd1,
        S_GAP   = 3'd2,
        S_DONE  = 3'd3
`ifdef SEQ_GEN_PARITY_EN
        ,
        S_PAR   = 3'd4
`endif
    } state_t;

    state_t           r_state;
    logic [PAT_W-1:0] r_pat;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic             r_x;
    logic             r_xVld;
    logic             r_busy;
    logic             r_done;

    state_t           w_nextState;
    logic [PAT_W-1:0] w_nextPat;
    logic [CNT_W-1:0] w_nextCnt;
    logic [IDX_W-1:0] w_nextIdx;
    logic             w_nextX;
    logic             w_nextXVld;
    logic             w_nextBusy;
    logic             w_nextDone;
    logic [CNT_W-1:0] w_repsEff;

    // A zero repeat count still sends the pattern once.
    assign w_repsEff = (reps == '0) ? CNT_W'(1) : reps;

`ifdef SEQ_GEN_PARITY_EN
    logic w_parity;
    assign w_parity = ^r_pat;
`endif

    // State and datapath registers; reset aborts any transfer silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_pat   <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_x     <= 1'b0;
            r_xVld  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_pat   <= w_nextPat;
            r_cnt   <= w_nextCnt;
            r_idx   <= w_nextIdx;
            r_x     <= w_nextX;
            r_xVld  <= w_nextXVld;
            r_busy  <= w_nextBusy;
            r_done  <= w_nextDone;
        end
    end

    // Next state plus the output values of the next visible cycle. In SHIFT,
    // r_idx is the bit shown this cycle when r_xVld is set, otherwise the bit
    // still pending after a stall; the x_vld register doubles as that flag.
    always_comb begin
        w_nextState = r_state;
        w_nextPat   = r_pat;
        w_nextCnt   = r_cnt;
        w_nextIdx   = r_idx;
        w_nextX     = 1'b0;
        w_nextXVld  = 1'b0;
        w_nextBusy  = 1'b0;
        w_nextDone  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nextState = S_SHIFT;
                    w_nextPat   = pattern;
                    w_nextCnt   = w_repsEff;
                    w_nextIdx   = LAST_IDX;
                    w_nextX     = pattern[PAT_W-1];
                    w_nextXVld  = 1'b1;
                end
            end

            S_SHIFT: begin
                if (r_xVld && (r_idx == '0)) begin
`ifdef SEQ_GEN_PARITY_EN
                    w_nextState = S_PAR;
                    w_nextX     = stall ? r_x : w_parity;
                    w_nextXVld  = ~stall;
`else
                    if (r_cnt > CNT_W'(1)) begin
                        w_nextState = S_GAP;
                        w_nextCnt   = r_cnt - CNT_W'(1);
                    end else begin
                        w_nextState = S_DONE;
                    end
`endif
                end else begin
                    w_nextIdx = r_xVld ? (r_idx - IDX_W'(1)) : r_idx;
                    if (stall) begin
                        w_nextX    = r_x;
                        w_nextXVld = 1'b0;
                    end else begin
                        w_nextX    = r_pat[w_nextIdx];
                        w_nextXVld = 1'b1;
                    end
                end
            end

`ifdef SEQ_GEN_PARITY_EN
            S_PAR: begin
                if (r_xVld) begin
                    if (r_cnt > CNT_W'(1)) begin
                        w_nextState = S_GAP;
                        w_nextCnt   = r_cnt - CNT_W'(1);
                    end else begin
                        w_nextState = S_DONE;
                    end
                end else if (stall) begin
                    w_nextX    = r_x;
                    w_nextXVld = 1'b0;
                end else begin
                    w_nextX    = w_parity;
                    w_nextXVld = 1'b1;
                end
            end
`endif

            S_GAP: begin
                w_nextState = S_SHIFT;
                w_nextIdx   = LAST_IDX;
                w_nextX     = r_pat[PAT_W-1];
                w_nextXVld  = 1'b1;
            end

            S_DONE: begin
                w_nextState = S_IDLE;
            end

            default: begin
                w_nextState = S_IDLE;
            end
        endcase

        w_nextBusy = (w_nextState == S_SHIFT) || (w_nextState == S_GAP)
`ifdef SEQ_GEN_PARITY_EN
                     || (w_nextState == S_PAR)
`endif
                     ;
        w_nextDone = (w_nextState == S_DONE);
    end

    assign x     = r_x;
    assign x_vld = r_xVld;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule
